// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-fronted byte memory: command opcodes,
// field widths and the address range helper.
package spi_ram_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CMD_W  = 10;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // An address can name more words than a shallow array actually holds.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/spi_ram_if.sv
// Command/response bundle between the SPI front end (master) and the
// memory (slave).
interface spi_ram_if;
    import spi_ram_pkg::*;

    logic [CMD_W-1:0]  din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;

    modport master (output din, output rx_valid, input dout, input tx_valid);
    modport slave  (input din, input rx_valid, output dout, output tx_valid);

endinterface

// File: rtl/spi_ram.sv
// Single-port byte memory driven by 10-bit SPI commands: latch write/read
// addresses, write bytes, and return read bytes with a one-cycle strobe.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_ram_if.slave   bus
);

    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0]    mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [DATA_W-1:0]    dout_q;
    logic                 tx_valid_q;

    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic [DATA_W-1:0]    payload;
    logic                 wr_ok;
    logic                 rd_ok;
    logic [MEM_AW-1:0]    wr_idx;
    logic [MEM_AW-1:0]    rd_idx;

    assign opcode   = bus.din[CMD_W-1:CMD_W-2];
    assign payload  = bus.din[DATA_W-1:0];
    assign cmd_addr = bus.din[ADDR_SIZE-1:0];

    assign wr_ok  = addr_in_range(32'(wr_addr), MEM_DEPTH);
    assign rd_ok  = addr_in_range(32'(rd_addr), MEM_DEPTH);
    assign wr_idx = MEM_AW'(wr_addr);
    assign rd_idx = MEM_AW'(rd_addr);

    // The array sits in the reset block only so that no write can land while
    // rst_n is low; its contents are never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            case (opcode)
                OP_WR_ADDR: if (bus.rx_valid) wr_addr <= cmd_addr;
                OP_WR_DATA: if (bus.rx_valid && wr_ok) mem[wr_idx] <= payload;
                OP_RD_ADDR: if (bus.rx_valid) rd_addr <= cmd_addr;
                default: begin
                    dout_q     <= rd_ok ? mem[rd_idx] : '0;
                    tx_valid_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: a full-depth instance and a 128-word instance
// share the clock and reset.
module tb_spi_ram;
    import spi_ram_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    spi_ram_if bus_a ();
    spi_ram_if bus_b ();

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    spi_ram #(.MEM_DEPTH(128), .ADDR_SIZE(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One command per call: it is presented for exactly one rising edge and
    // then withdrawn, so results can be checked at leisure afterwards.
    task automatic applyStimulus(input bit use_b, input logic [1:0] op,
                                 input logic [7:0] payload, input logic valid);
        @(negedge clk);
        if (use_b) begin
            bus_b.din      = {op, payload};
            bus_b.rx_valid = valid;
        end else begin
            bus_a.din      = {op, payload};
            bus_a.rx_valid = valid;
        end
        @(posedge clk);
        #1;
        bus_a.din = '0; bus_a.rx_valid = 1'b0;
        bus_b.din = '0; bus_b.rx_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_a.din = '0; bus_a.rx_valid = 1'b0;
        bus_b.din = '0; bus_b.rx_valid = 1'b0;
        for (int i = 0; i < 256; i++) dut_a.mem[i] = 8'h00;
        for (int i = 0; i < 128; i++) dut_b.mem[i] = 8'h00;
        #1;
        checkOutput("reset_dout", 32'(bus_a.dout), 32'h0);
        checkOutput("reset_tx_valid", 32'(bus_a.tx_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read of address 0x0A
        applyStimulus(0, OP_WR_ADDR, 8'h0A, 1'b1);
        checkOutput("t1_tx_after_wa", 32'(bus_a.tx_valid), 32'h0);
        applyStimulus(0, OP_WR_DATA, 8'h13, 1'b1);
        checkOutput("t1_tx_after_wd", 32'(bus_a.tx_valid), 32'h0);
        applyStimulus(0, OP_RD_ADDR, 8'h0A, 1'b1);
        checkOutput("t1_tx_after_ra", 32'(bus_a.tx_valid), 32'h0);
        applyStimulus(0, OP_RD_DATA, 8'($urandom_range(0, 255)), 1'b1);
        checkOutput("t1_dout", 32'(bus_a.dout), 32'h13);
        checkOutput("t1_tx_valid", 32'(bus_a.tx_valid), 32'h1);

        // Unqualified address/data commands must be ignored
        applyStimulus(0, OP_WR_ADDR, 8'h05, 1'b0);
        checkOutput("t2_tx_dropped", 32'(bus_a.tx_valid), 32'h0);
        applyStimulus(0, OP_WR_DATA, 8'h55, 1'b0);
        checkOutput("t2_wr_addr_held", 32'(dut_a.wr_addr), 32'h0A);
        checkOutput("t2_mem5", 32'(dut_a.mem[5]), 32'h00);
        checkOutput("t2_mem10", 32'(dut_a.mem[10]), 32'h13);
        applyStimulus(0, OP_RD_ADDR, 8'h05, 1'b1);
        applyStimulus(0, OP_RD_DATA, 8'h00, 1'b1);
        checkOutput("t2_read5", 32'(bus_a.dout), 32'h00);

        // Both ends of the array and back-to-back reads
        applyStimulus(0, OP_WR_ADDR, 8'h00, 1'b1);
        applyStimulus(0, OP_WR_DATA, 8'hAA, 1'b1);
        applyStimulus(0, OP_WR_ADDR, 8'hFF, 1'b1);
        applyStimulus(0, OP_WR_DATA, 8'hBB, 1'b1);
        applyStimulus(0, OP_RD_ADDR, 8'hFF, 1'b1);
        applyStimulus(0, OP_RD_DATA, 8'h00, 1'b1);
        checkOutput("t3_dout_255", 32'(bus_a.dout), 32'hBB);
        checkOutput("t3_tx_255", 32'(bus_a.tx_valid), 32'h1);
        applyStimulus(0, OP_RD_ADDR, 8'h00, 1'b1);
        checkOutput("t3_tx_after_ra", 32'(bus_a.tx_valid), 32'h0);
        checkOutput("t3_dout_held", 32'(bus_a.dout), 32'hBB);
        applyStimulus(0, OP_RD_DATA, 8'h00, 1'b1);
        checkOutput("t3_dout_0", 32'(bus_a.dout), 32'hAA);
        checkOutput("t3_tx_0", 32'(bus_a.tx_valid), 32'h1);
        applyStimulus(0, OP_RD_ADDR, 8'hFF, 1'b1);
        applyStimulus(0, OP_RD_DATA, 8'h00, 1'b1);
        applyStimulus(0, OP_RD_DATA, 8'h00, 1'b1);
        checkOutput("t3_b2b_dout", 32'(bus_a.dout), 32'hBB);
        checkOutput("t3_b2b_tx", 32'(bus_a.tx_valid), 32'h1);

        // Read executes even with rx_valid low; strobe lasts one cycle
        applyStimulus(0, OP_RD_ADDR, 8'h00, 1'b1);
        applyStimulus(0, OP_RD_DATA, 8'h00, 1'b0);
        checkOutput("t4_dout", 32'(bus_a.dout), 32'hAA);
        checkOutput("t4_tx", 32'(bus_a.tx_valid), 32'h1);
        applyStimulus(0, OP_WR_ADDR, 8'h03, 1'b1);
        checkOutput("t4_tx_drop", 32'(bus_a.tx_valid), 32'h0);
        checkOutput("t4_dout_held", 32'(bus_a.dout), 32'hAA);

        // Asynchronous reset between edges right after a good read
        applyStimulus(0, OP_RD_ADDR, 8'hFF, 1'b1);
        applyStimulus(0, OP_RD_DATA, 8'h00, 1'b1);
        checkOutput("t5_pre_dout", 32'(bus_a.dout), 32'hBB);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_dout", 32'(bus_a.dout), 32'h0);
        checkOutput("t5_rst_tx", 32'(bus_a.tx_valid), 32'h0);
        checkOutput("t5_rst_rd_addr", 32'(dut_a.rd_addr), 32'h0);
        checkOutput("t5_rst_wr_addr", 32'(dut_a.wr_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, OP_RD_DATA, 8'h00, 1'b1);
        checkOutput("t5_read_addr0", 32'(bus_a.dout), 32'hAA);
        applyStimulus(0, OP_RD_ADDR, 8'hFF, 1'b1);
        applyStimulus(0, OP_RD_DATA, 8'h00, 1'b1);
        checkOutput("t5_read_addr255", 32'(bus_a.dout), 32'hBB);

        // Shallow instance: address 200 is beyond its 128 words
        applyStimulus(1, OP_WR_ADDR, 8'd72, 1'b1);
        applyStimulus(1, OP_WR_DATA, 8'h11, 1'b1);
        applyStimulus(1, OP_WR_ADDR, 8'd200, 1'b1);
        applyStimulus(1, OP_WR_DATA, 8'h77, 1'b1);
        checkOutput("t6_mem72", 32'(dut_b.mem[72]), 32'h11);
        applyStimulus(1, OP_RD_ADDR, 8'd72, 1'b1);
        applyStimulus(1, OP_RD_DATA, 8'h00, 1'b1);
        checkOutput("t6_read72", 32'(bus_b.dout), 32'h11);
        applyStimulus(1, OP_RD_ADDR, 8'd200, 1'b1);
        applyStimulus(1, OP_RD_DATA, 8'h00, 1'b1);
        checkOutput("t6_read200", 32'(bus_b.dout), 32'h00);
        checkOutput("t6_tx200", 32'(bus_b.tx_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
